// File: rtl/tlb_op_ctrl_pkg.sv
// rtl/tlb_op_ctrl_pkg.sv - shared constants and types for the TLB-op sequencer
package tlb_op_ctrl_pkg;

  // Packed TLB entry: {vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1}
  localparam int TLB_ENTRY_W = 78;

  localparam int E_VPN2_LSB = 59;
  localparam int E_VPN2_W   = 19;
  localparam int E_ASID_LSB = 51;
  localparam int E_ASID_W   = 8;
  localparam int E_G        = 50;
  localparam int E_PFN0_LSB = 30;
  localparam int E_PFN_W    = 20;
  localparam int E_C0_LSB   = 27;
  localparam int E_C_W      = 3;
  localparam int E_D0       = 26;
  localparam int E_V0       = 25;
  localparam int E_PFN1_LSB = 5;
  localparam int E_C1_LSB   = 2;
  localparam int E_D1       = 1;
  localparam int E_V1       = 0;

  // Bit positions inside the one-hot ws_op vector
  localparam int OP_TLBP    = 0;
  localparam int OP_TLBR    = 1;
  localparam int OP_TLBWI   = 2;
  localparam int OP_MTC0_HI = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PROBE   = 2'd1,
    ST_COMMIT  = 2'd2,
    ST_REFETCH = 2'd3
  } state_t;

  // Encoded form of the accepted op after priority resolution
  typedef enum logic [1:0] {
    K_TLBP    = 2'd0,
    K_TLBR    = 2'd1,
    K_TLBWI   = 2'd2,
    K_MTC0_HI = 2'd3
  } op_kind_t;

endpackage

// File: rtl/tlb_op_ctrl.sv
// rtl/tlb_op_ctrl.sv - sequences TLBP/TLBR/TLBWI/MTC0-EntryHi at write-back
module tlb_op_ctrl
  import tlb_op_ctrl_pkg::*;
#(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ws_valid,
  input  logic [3:0]             ws_op,
  input  logic                   ws_ex,
  input  logic [31:0]            ws_pc,
  input  logic [31:0]            cp0_entryhi,
  input  logic [31:0]            cp0_entrylo0,
  input  logic [31:0]            cp0_entrylo1,
  input  logic [31:0]            cp0_index,
  output logic [18:0]            s1_vpn2,
  output logic [7:0]             s1_asid,
  input  logic                   s1_found,
  input  logic [IDX_W-1:0]       s1_index,
  output logic                   w_we,
  output logic [IDX_W-1:0]       w_index,
  output logic [TLB_ENTRY_W-1:0] w_entry,
  output logic [IDX_W-1:0]       r_index,
  output logic                   tlbp_commit,
  output logic                   tlbr_commit,
  output logic                   tlbp_found,
  output logic [IDX_W-1:0]       tlbp_index,
  output logic                   busy,
  output logic                   ws_done,
  output logic                   refetch_req,
  output logic [31:0]            refetch_pc,
  input  logic                   refetch_ack
);

  localparam int unused_tlbnum = TLBNUM;

  state_t           state_q, state_d;
  op_kind_t         kind_q, op_sel;
  logic [31:0]      pc_q;
  logic [18:0]      s1_vpn2_q;
  logic [7:0]       s1_asid_q;
  logic             found_q;
  logic [IDX_W-1:0] index_q;
  logic             mtc0_first_q;
  logic             accept;

  // Fields of the CP0 registers that never reach the TLB
  logic unused_bits;
  assign unused_bits = ^{cp0_entryhi[12:8], cp0_entrylo0[31:26],
                         cp0_entrylo1[31:26], cp0_index[31:IDX_W]};

  // Only a fault-free instruction in an idle controller may start an op
  assign accept = !rst && (state_q == ST_IDLE) && ws_valid && (|ws_op) && !ws_ex;

  // Resolve multiple set op bits: tlbp > tlbr > tlbwi > mtc0
  always_comb begin
    op_sel = K_MTC0_HI;
    if (ws_op[OP_TLBP])       op_sel = K_TLBP;
    else if (ws_op[OP_TLBR])  op_sel = K_TLBR;
    else if (ws_op[OP_TLBWI]) op_sel = K_TLBWI;
  end

  // State register and per-op context captured at accept
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      kind_q       <= K_TLBP;
      pc_q         <= '0;
      mtc0_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mtc0_first_q <= accept && (op_sel == K_MTC0_HI);
      if (accept) begin
        kind_q <= op_sel;
        pc_q   <= ws_pc;
      end
    end
  end

  // Search key and probe result are held between probes
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vpn2_q <= '0;
      s1_asid_q <= '0;
      found_q   <= 1'b0;
      index_q   <= '0;
    end else if (state_q == ST_PROBE) begin
      s1_vpn2_q <= cp0_entryhi[31:13];
      s1_asid_q <= cp0_entryhi[7:0];
      found_q   <= s1_found;
      index_q   <= s1_index;
    end
  end

  // Search port drives EntryHi live during PROBE, otherwise the last key
  always_comb begin
    s1_vpn2 = s1_vpn2_q;
    s1_asid = s1_asid_q;
    if (state_q == ST_PROBE) begin
      s1_vpn2 = cp0_entryhi[31:13];
      s1_asid = cp0_entryhi[7:0];
    end
  end

  assign tlbp_found = found_q;
  assign tlbp_index = index_q;

  // Next-state and strobe decode; everything is forced quiet under reset
  always_comb begin
    state_d     = state_q;
    busy        = 1'b0;
    ws_done     = 1'b0;
    w_we        = 1'b0;
    w_index     = '0;
    w_entry     = '0;
    r_index     = '0;
    tlbp_commit = 1'b0;
    tlbr_commit = 1'b0;
    refetch_req = 1'b0;
    refetch_pc  = '0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            busy = 1'b1;
            case (op_sel)
              K_TLBP:  state_d = ST_PROBE;
              K_TLBR,
              K_TLBWI: state_d = ST_COMMIT;
              default: state_d = ST_REFETCH;
            endcase
          end
        end
        ST_PROBE: begin
          busy    = 1'b1;
          state_d = ST_COMMIT;
        end
        ST_COMMIT: begin
          busy    = 1'b1;
          ws_done = 1'b1;
          state_d = (kind_q == K_TLBP) ? ST_IDLE : ST_REFETCH;
          case (kind_q)
            K_TLBP: tlbp_commit = 1'b1;
            K_TLBR: begin
              tlbr_commit = 1'b1;
              r_index     = cp0_index[IDX_W-1:0];
            end
            K_TLBWI: begin
              w_we    = 1'b1;
              w_index = cp0_index[IDX_W-1:0];
              w_entry[E_VPN2_LSB +: E_VPN2_W] = cp0_entryhi[31:13];
              w_entry[E_ASID_LSB +: E_ASID_W] = cp0_entryhi[7:0];
              w_entry[E_G]                    = cp0_entrylo0[0] & cp0_entrylo1[0];
              w_entry[E_PFN0_LSB +: E_PFN_W]  = cp0_entrylo0[25:6];
              w_entry[E_C0_LSB +: E_C_W]      = cp0_entrylo0[5:3];
              w_entry[E_D0]                   = cp0_entrylo0[2];
              w_entry[E_V0]                   = cp0_entrylo0[1];
              w_entry[E_PFN1_LSB +: E_PFN_W]  = cp0_entrylo1[25:6];
              w_entry[E_C1_LSB +: E_C_W]      = cp0_entrylo1[5:3];
              w_entry[E_D1]                   = cp0_entrylo1[2];
              w_entry[E_V1]                   = cp0_entrylo1[1];
            end
            default: ;
          endcase
        end
        ST_REFETCH: begin
          busy        = 1'b1;
          refetch_req = 1'b1;
          refetch_pc  = pc_q + 32'd4;
          ws_done     = mtc0_first_q;
          if (refetch_ack) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/tlb_op_ctrl.md
Name: tlb_op_ctrl

Overview: Sequences the TLB-management instructions TLBP, TLBR and TLBWI, plus MTC0 to EntryHi, once they reach the write-back stage. It drives the TLB search port 1, the TLB write and read ports, and the CP0 tlbp/tlbr strobes. It stalls write-back while an operation is in flight, then issues a front-end refetch at pc+4 so later instructions see the new translation state. It sits between the WB stage, the cp0 block and the TLB array.

Parameters:
TLBNUM, 16, number of TLB entries
IDX_W, 4, index width; must equal log2(TLBNUM)

Ports:
clk  in  1  clock
rst  in  1  reset
ws_valid  in  1  WB stage holds a valid instruction
ws_op  in  4  one-hot {mtc0_entryhi, tlbwi, tlbr, tlbp}
ws_ex  in  1  WB instruction raises an exception
ws_pc  in  32  PC of the WB instruction
cp0_entryhi  in  32  CP0 EntryHi
cp0_entrylo0  in  32  CP0 EntryLo0
cp0_entrylo1  in  32  CP0 EntryLo1
cp0_index  in  32  CP0 Index
s1_vpn2  out  19  TLB search port 1 VPN2
s1_asid  out  8  TLB search port 1 ASID
s1_found  in  1  TLB search hit (combinational from the TLB)
s1_index  in  IDX_W  TLB search hit index
w_we  out  1  TLB write enable
w_index  out  IDX_W  TLB write index
w_entry  out  TLB_ENTRY_W  packed TLB entry to write
r_index  out  IDX_W  TLB read index
tlbp_commit  out  1  one-cycle strobe to cp0 tlbp input
tlbr_commit  out  1  one-cycle strobe to cp0 tlbr input
tlbp_found  out  1  registered s1_found, forwarded to cp0
tlbp_index  out  IDX_W  registered s1_index, forwarded to cp0
busy  out  1  stall WB and the stages upstream of it
ws_done  out  1  one-cycle pulse: the WB TLB op is allowed to retire
refetch_req  out  1  front-end redirect request
refetch_pc  out  32  redirect target
refetch_ack  in  1  front end has accepted the redirect

Behaviour:
- Reset: state IDLE; all outputs 0 (w_we, strobes, tlbp_found/index, busy, ws_done, refetch_req, refetch_pc).
- Accept condition (IDLE only): ws_valid & |ws_op & !ws_ex. On accept, latch ws_pc and the op. If more than one ws_op bit is set, priority is tlbp > tlbr > tlbwi > mtc0.
- ws_ex=1 suppresses acceptance: the exception wins and the controller stays IDLE.
- busy = (state != IDLE) | accept.
- State machine:
  - TLBP path: IDLE -> PROBE -> COMMIT -> IDLE.
  - TLBR and TLBWI paths: IDLE -> COMMIT -> REFETCH.
  - MTC0-to-EntryHi path: IDLE -> REFETCH. cp0 performs the register write itself in the accept cycle.
- PROBE: s1_vpn2 = cp0_entryhi[31:13], s1_asid = cp0_entryhi[7:0]. s1_found and s1_index are registered into tlbp_found/tlbp_index at the end of PROBE. Outside PROBE, s1_* hold their previous value.
- COMMIT (exactly 1 cycle):
  - tlbp: tlbp_commit=1.
  - tlbr: tlbr_commit=1, r_index = cp0_index[IDX_W-1:0]. The TLB read is combinational; cp0 captures it the same cycle.
  - tlbwi: w_we=1, w_index = cp0_index[IDX_W-1:0]. w_entry = {entryhi[31:13], entryhi[7:0], lo0[0]&lo1[0], lo0[25:6], lo0[5:3], lo0[2], lo0[1], lo1[25:6], lo1[5:3], lo1[2], lo1[1]}.
  - ws_done=1 in COMMIT for every path that has a COMMIT state.
- REFETCH:
  - refetch_req=1, refetch_pc = latched pc + 4 (32-bit wrap: 0xFFFFFFFC -> 0x00000000).
  - Held until refetch_ack is sampled high, then IDLE with refetch_req=0 in the next cycle.
  - refetch_ack is ignored outside REFETCH.
  - For mtc0, ws_done pulses in the REFETCH entry cycle.
- Back-to-back ops: a new op can be accepted in the cycle after the return to IDLE; there is no accept in the same cycle as the ack.
- Reset mid-op: returns immediately to IDLE. No write, strobe or refetch is produced, and a pending refetch is dropped.

Decomposition:
- Shared package holds: TLB_ENTRY_W=78; w_entry field offsets; ws_op bit positions (OP_TLBP=0, OP_TLBR=1, OP_TLBWI=2, OP_MTC0_HI=3); state encodings.
- Single module, no sub-module.

Test Plan:
- TLBP hit: EntryHi=0x00402005, TLB entry 7 holds vpn2=0x00201 asid=5 -> PROBE then COMMIT; tlbp_commit pulses; tlbp_found=1, tlbp_index=7; no refetch_req.
- TLBP miss: EntryHi=0x12345003 with no matching entry -> tlbp_found=0; busy high exactly 2 cycles after accept.
- TLBWI: Index=3, Lo0=0x00000047, Lo1=0x00000087, pc=0xBFC00100 -> one-cycle w_we with w_index=3 and g=1; refetch_pc=0xBFC00104, held over 3 stall cycles until refetch_ack.
- TLBR plus exception: tlbr with ws_ex=1 -> no accept, busy=0, no strobes. Same tlbr with ws_ex=0 -> tlbr_commit pulse, r_index=cp0_index[3:0], then refetch.
- MTC0 EntryHi at pc=0xFFFFFFFC -> no COMMIT state; refetch_pc=0x00000000; ws_done pulses once.
- Reset asserted during REFETCH -> refetch_req=0 and state IDLE the next cycle; a subsequent tlbp runs normally.
